// File: rtl/put_token_controller.sv
// rtl/put_token_controller.sv - put-side skid buffer and one-hot token controller of the mixed-clock FIFO
//
// Ports:
//   clk_put        put-domain clock
//   reset          asynchronous active-low reset
//   req_put        sender has a valid word on data_put
//   data_put       sender data word
//   put_ready      a word can be accepted this cycle
//   cell_full      per-cell full flags
//   cell_ptok_hold per-cell put-token hold (collision) flags
//   enable_put     one-hot write enable to the token cell (zero when not issuing)
//   data_out       put data bus shared by all cells
//   ptok           one-hot put token position
//   full_put       token cell is full
//   put_count      words issued to cells, wraps
module put_token_controller #(
   parameter int NUM_CELLS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_put,
   input  logic                  reset,
   input  logic                  req_put,
   input  logic [DATA_WIDTH-1:0] data_put,
   output logic                  put_ready,
   input  logic [NUM_CELLS-1:0]  cell_full,
   input  logic [NUM_CELLS-1:0]  cell_ptok_hold,
   output logic [NUM_CELLS-1:0]  enable_put,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [NUM_CELLS-1:0]  ptok,
   output logic                  full_put,
   output logic [CNT_WIDTH-1:0]  put_count
);

   localparam logic [NUM_CELLS-1:0] TOK_INIT = {{(NUM_CELLS-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  tok_full;
   logic                  tok_hold;
   logic                  issue;
   logic                  accept;

   // Only the token cell's flags matter; other cells are masked off by ptok.
   assign tok_full  = |(ptok & cell_full);
   assign tok_hold  = |(ptok & cell_ptok_hold);
   assign full_put  = tok_full;

   // Full and hold both block; the token never skips a blocked cell.
   assign issue     = valid_q & ~tok_full & ~tok_hold;

   // Accepting in the issue cycle keeps the skid register streaming at 1 word/cycle.
   assign put_ready = ~valid_q | issue;
   assign accept    = req_put & put_ready;

   assign enable_put = issue ? ptok : '0;
   assign data_out   = data_q;

   always_ff @(posedge clk_put or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         ptok      <= TOK_INIT;
         put_count <= '0;
      end else begin
         if (accept) begin
            valid_q <= 1'b1;
            data_q  <= data_put;
         end else if (issue) begin
            valid_q <= 1'b0;
         end

         if (issue) begin
            ptok      <= {ptok[NUM_CELLS-2:0], ptok[NUM_CELLS-1]};
            put_count <= put_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_put_token_controller.sv
// tb/tb_put_token_controller.sv - directed self-checking bench for put_token_controller
module tb_put_token_controller;

   localparam int NC = 4;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk_put = 1'b0;
   logic          reset   = 1'b0;
   logic          req_put = 1'b0;
   logic [DW-1:0] data_put = '0;
   logic          put_ready;
   logic [NC-1:0] cell_full = '0;
   logic [NC-1:0] cell_ptok_hold = '0;
   logic [NC-1:0] enable_put;
   logic [DW-1:0] data_out;
   logic [NC-1:0] ptok;
   logic          full_put;
   logic [CW-1:0] put_count;

   int errors = 0;
   int checks = 0;

   put_token_controller #(.NUM_CELLS(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk_put        (clk_put),
      .reset          (reset),
      .req_put        (req_put),
      .data_put       (data_put),
      .put_ready      (put_ready),
      .cell_full      (cell_full),
      .cell_ptok_hold (cell_ptok_hold),
      .enable_put     (enable_put),
      .data_out       (data_out),
      .ptok           (ptok),
      .full_put       (full_put),
      .put_count      (put_count)
   );

   always #5 clk_put = ~clk_put;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk_put);
      #1;
   endtask

   initial begin
      // Reset held
      #12;
      chk("rst_ptok",   32'(ptok), 32'h1);
      chk("rst_en",     32'(enable_put), 32'h0);
      chk("rst_ready",  32'(put_ready), 32'h1);
      chk("rst_full",   32'(full_put), 32'h0);
      chk("rst_cnt",    32'(put_count), 32'h0);
      chk("rst_data",   32'(data_out), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      chk("idle_ptok",  32'(ptok), 32'h1);
      chk("idle_en",    32'(enable_put), 32'h0);

      // Streaming four words A0..A3
      req_put = 1'b1; data_put = 8'hA0;
      tick();
      data_put = 8'hA1; #1;
      chk("s0_en",   32'(enable_put), 32'b0001);
      chk("s0_data", 32'(data_out), 32'hA0);
      chk("s0_rdy",  32'(put_ready), 32'h1);
      tick();
      data_put = 8'hA2; #1;
      chk("s1_en",   32'(enable_put), 32'b0010);
      chk("s1_data", 32'(data_out), 32'hA1);
      tick();
      data_put = 8'hA3; #1;
      chk("s2_en",   32'(enable_put), 32'b0100);
      chk("s2_data", 32'(data_out), 32'hA2);
      tick();
      req_put = 1'b0; #1;
      chk("s3_en",   32'(enable_put), 32'b1000);
      chk("s3_data", 32'(data_out), 32'hA3);
      tick();
      chk("s_en_idle", 32'(enable_put), 32'h0);
      chk("s_ptok_wrap", 32'(ptok), 32'b0001);
      chk("s_cnt",   32'(put_count), 32'd4);

      // Full stall at cell 2
      req_put = 1'b1; data_put = 8'h01;
      tick();
      data_put = 8'h02;
      tick();
      req_put = 1'b0; cell_full = 4'b0100;
      tick();
      chk("f_ptok",  32'(ptok), 32'b0100);
      chk("f_full_idle", 32'(full_put), 32'h1);
      chk("f_rdy_idle",  32'(put_ready), 32'h1);
      req_put = 1'b1; data_put = 8'h33;
      tick();
      req_put = 1'b0; #1;
      chk("f_en",    32'(enable_put), 32'h0);
      chk("f_full",  32'(full_put), 32'h1);
      chk("f_rdy",   32'(put_ready), 32'h0);
      chk("f_data",  32'(data_out), 32'h33);
      tick();
      chk("f_en2",   32'(enable_put), 32'h0);
      chk("f_data2", 32'(data_out), 32'h33);
      chk("f_ptok2", 32'(ptok), 32'b0100);
      cell_full = '0; #1;
      chk("f_rel_en",  32'(enable_put), 32'b0100);
      chk("f_rel_rdy", 32'(put_ready), 32'h1);
      chk("f_rel_full",32'(full_put), 32'h0);
      tick();
      chk("f_ptok3", 32'(ptok), 32'b1000);
      chk("f_cnt",   32'(put_count), 32'd7);
      chk("f_en3",   32'(enable_put), 32'h0);

      // Hold collision at cell 1
      req_put = 1'b1; data_put = 8'h44;
      tick();
      req_put = 1'b0;
      tick();
      req_put = 1'b1; data_put = 8'h55;
      tick();
      req_put = 1'b0;
      tick();
      chk("h_ptok0", 32'(ptok), 32'b0010);
      cell_ptok_hold = 4'b0010; req_put = 1'b1; data_put = 8'h5C;
      tick();
      req_put = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("h_en_blk",   32'(enable_put), 32'h0);
         chk("h_ptok_blk", 32'(ptok), 32'b0010);
         chk("h_full_blk", 32'(full_put), 32'h0);
         tick();
      end
      cell_ptok_hold = '0; #1;
      chk("h_en",    32'(enable_put), 32'b0010);
      chk("h_data",  32'(data_out), 32'h5C);
      tick();
      chk("h_ptok1", 32'(ptok), 32'b0100);
      chk("h_cnt",   32'(put_count), 32'd10);

      // Back-pressure: 0x11 blocked, 0x22 waiting on req_put
      cell_full = 4'b0100; req_put = 1'b1; data_put = 8'h11;
      tick();
      data_put = 8'h22; #1;
      chk("b_rdy",   32'(put_ready), 32'h0);
      chk("b_data",  32'(data_out), 32'h11);
      chk("b_en",    32'(enable_put), 32'h0);
      tick();
      chk("b_data2", 32'(data_out), 32'h11);
      cell_full = '0; #1;
      chk("b_en_iss",  32'(enable_put), 32'b0100);
      chk("b_data_iss",32'(data_out), 32'h11);
      chk("b_rdy_iss", 32'(put_ready), 32'h1);
      tick();
      req_put = 1'b0; #1;
      chk("b_en2",   32'(enable_put), 32'b1000);
      chk("b_data3", 32'(data_out), 32'h22);
      tick();
      chk("b_ptok",  32'(ptok), 32'b0001);
      chk("b_cnt",   32'(put_count), 32'd12);

      // Reset mid-stream, word pending at cell 3
      req_put = 1'b1; data_put = 8'h61;
      tick();
      data_put = 8'h62;
      tick();
      data_put = 8'h63;
      tick();
      data_put = 8'h64;
      tick();
      req_put = 1'b0; #1;
      chk("r_ptok",  32'(ptok), 32'b1000);
      chk("r_en",    32'(enable_put), 32'b1000);
      chk("r_cnt",   32'(put_count), 32'd15);
      reset = 1'b0; #1;
      chk("r_en_async",   32'(enable_put), 32'h0);
      chk("r_ptok_async", 32'(ptok), 32'b0001);
      chk("r_data_async", 32'(data_out), 32'h0);
      tick();
      reset = 1'b1;
      tick();
      chk("r_ptok_rel", 32'(ptok), 32'b0001);
      chk("r_cnt_rel",  32'(put_count), 32'd0);
      chk("r_rdy_rel",  32'(put_ready), 32'h1);
      chk("r_en_rel",   32'(enable_put), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
